// File: rtl/me_frame_scheduler.sv
// me_frame_scheduler: frame-level sequencer for the full-search motion
// estimation core. Walks MB_COLS x MB_ROWS macroblocks in raster order,
// runs one req/ack transaction with the core per macroblock, and forwards
// each captured result over a valid/ready port.
// Optional feature macro: ME_SCHED_STATS_EN adds sad_sum / mb_done counters.
module me_frame_scheduler #(
  parameter int MB_COLS     = 4,
  parameter int MB_ROWS     = 3,
  parameter int SAD_WIDTH   = 16,
  parameter int MVEC_WIDTH  = 12,
  parameter int COORD_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   done_aborted,
  output logic [COORD_WIDTH-1:0] mb_x,
  output logic [COORD_WIDTH-1:0] mb_y,
  output logic                   me_req,
  input  logic                   me_ack,
  input  logic [SAD_WIDTH-1:0]   me_min_sad,
  input  logic [MVEC_WIDTH-1:0]  me_min_mvec,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SAD_WIDTH-1:0]   res_sad,
  output logic [MVEC_WIDTH-1:0]  res_mvec,
  output logic [COORD_WIDTH-1:0] res_mb_x,
  output logic [COORD_WIDTH-1:0] res_mb_y
`ifdef ME_SCHED_STATS_EN
  ,
  output logic [SAD_WIDTH+15:0]  sad_sum,
  output logic [15:0]            mb_done
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_REL  = 3'd2,
    S_PUSH = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [COORD_WIDTH-1:0] LAST_X = COORD_WIDTH'(MB_COLS - 1);
  localparam logic [COORD_WIDTH-1:0] LAST_Y = COORD_WIDTH'(MB_ROWS - 1);

  state_t                 state_q, state_d;
  logic                   abort_pend_q, abort_pend_d;
  logic [COORD_WIDTH-1:0] mb_x_q, mb_x_d;
  logic [COORD_WIDTH-1:0] mb_y_q, mb_y_d;
  logic [SAD_WIDTH-1:0]   res_sad_q, res_sad_d;
  logic [MVEC_WIDTH-1:0]  res_mvec_q, res_mvec_d;
  logic [COORD_WIDTH-1:0] res_mb_x_q, res_mb_x_d;
  logic [COORD_WIDTH-1:0] res_mb_y_q, res_mb_y_d;
  logic                   busy_q, me_req_q, res_valid_q, done_q, done_aborted_q;
  logic                   last_mb;
  logic                   start_accept;

  assign last_mb      = (mb_x_q == LAST_X) && (mb_y_q == LAST_Y);
  assign start_accept = (state_q == S_IDLE) && start && !abort;

  // Next-state, raster counters, result capture and abort bookkeeping.
  always_comb begin
    state_d      = state_q;
    mb_x_d       = mb_x_q;
    mb_y_d       = mb_y_q;
    res_sad_d    = res_sad_q;
    res_mvec_d   = res_mvec_q;
    res_mb_x_d   = res_mb_x_q;
    res_mb_y_d   = res_mb_y_q;
    // An abort arriving in the decision cycle itself already counts.
    abort_pend_d = abort_pend_q | (abort && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        mb_x_d = '0;
        mb_y_d = '0;
        if (start_accept) state_d = S_REQ;
      end
      S_REQ: begin
        if (me_ack) begin
          res_sad_d  = me_min_sad;
          res_mvec_d = me_min_mvec;
          res_mb_x_d = mb_x_q;
          res_mb_y_d = mb_y_q;
          state_d    = S_REL;
        end
      end
      S_REL: begin
        // Core must drop ack (re-arm) before anything else happens.
        if (!me_ack) state_d = abort_pend_d ? S_FIN : S_PUSH;
      end
      S_PUSH: begin
        if (res_ready) begin
          if (abort_pend_d || last_mb) begin
            state_d = S_FIN;
          end else begin
            state_d = S_REQ;
            if (mb_x_q == LAST_X) begin
              mb_x_d = '0;
              mb_y_d = mb_y_q + COORD_WIDTH'(1);
            end else begin
              mb_x_d = mb_x_q + COORD_WIDTH'(1);
            end
          end
        end
      end
      S_FIN: begin
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered decoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      abort_pend_q   <= 1'b0;
      mb_x_q         <= '0;
      mb_y_q         <= '0;
      res_sad_q      <= '0;
      res_mvec_q     <= '0;
      res_mb_x_q     <= '0;
      res_mb_y_q     <= '0;
      busy_q         <= 1'b0;
      me_req_q       <= 1'b0;
      res_valid_q    <= 1'b0;
      done_q         <= 1'b0;
      done_aborted_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      abort_pend_q   <= abort_pend_d;
      mb_x_q         <= mb_x_d;
      mb_y_q         <= mb_y_d;
      res_sad_q      <= res_sad_d;
      res_mvec_q     <= res_mvec_d;
      res_mb_x_q     <= res_mb_x_d;
      res_mb_y_q     <= res_mb_y_d;
      busy_q         <= (state_d != S_IDLE);
      me_req_q       <= (state_d == S_REQ);
      res_valid_q    <= (state_d == S_PUSH);
      done_q         <= (state_d == S_FIN);
      done_aborted_q <= (state_d == S_FIN) && abort_pend_d;
    end
  end

  assign busy         = busy_q;
  assign me_req       = me_req_q;
  assign res_valid    = res_valid_q;
  assign done         = done_q;
  assign done_aborted = done_aborted_q;
  assign mb_x         = mb_x_q;
  assign mb_y         = mb_y_q;
  assign res_sad      = res_sad_q;
  assign res_mvec     = res_mvec_q;
  assign res_mb_x     = res_mb_x_q;
  assign res_mb_y     = res_mb_y_q;

`ifdef ME_SCHED_STATS_EN
  logic [SAD_WIDTH+15:0] sad_sum_q, sad_sum_d;
  logic [15:0]           mb_done_q, mb_done_d;
  logic [SAD_WIDTH+16:0] sad_sum_ext;
  logic                  res_accept;

  assign res_accept  = res_valid_q && res_ready;
  assign sad_sum_ext = {1'b0, sad_sum_q} + (SAD_WIDTH+17)'(res_sad_q);

  // Saturating per-frame statistics, cleared by an accepted start.
  always_comb begin
    sad_sum_d = sad_sum_q;
    mb_done_d = mb_done_q;
    if (start_accept) begin
      sad_sum_d = '0;
      mb_done_d = '0;
    end else if (res_accept) begin
      sad_sum_d = sad_sum_ext[SAD_WIDTH+16] ? '1 : sad_sum_ext[SAD_WIDTH+15:0];
      if (mb_done_q != 16'hFFFF) mb_done_d = mb_done_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_sum_q <= '0;
      mb_done_q <= '0;
    end else begin
      sad_sum_q <= sad_sum_d;
      mb_done_q <= mb_done_d;
    end
  end

  assign sad_sum = sad_sum_q;
  assign mb_done = mb_done_q;
`endif

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Testbench for me_frame_scheduler: 2x2 frame, behavioural ME core model,
// randomized ack/release delays, stalls, aborts and a reference model of
// which raster-ordered results must reach the output port.
module tb_me_frame_scheduler;
  localparam int C  = 2;
  localparam int R  = 2;
  localparam int SW = 16;
  localparam int MW = 12;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          me_ack = 1'b0;
  logic          res_ready = 1'b0;
  logic [SW-1:0] me_min_sad = '0;
  logic [MW-1:0] me_min_mvec = '0;
  logic          busy, done, done_aborted, me_req, res_valid;
  logic [CW-1:0] mb_x, mb_y, res_mb_x, res_mb_y;
  logic [SW-1:0] res_sad;
  logic [MW-1:0] res_mvec;
`ifdef ME_SCHED_STATS_EN
  logic [SW+15:0] sad_sum;
  logic [15:0]    mb_done;
`endif

  me_frame_scheduler #(
    .MB_COLS(C), .MB_ROWS(R), .SAD_WIDTH(SW), .MVEC_WIDTH(MW), .COORD_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .done_aborted(done_aborted),
    .mb_x(mb_x), .mb_y(mb_y),
    .me_req(me_req), .me_ack(me_ack), .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sad(res_sad), .res_mvec(res_mvec), .res_mb_x(res_mb_x), .res_mb_y(res_mb_y)
`ifdef ME_SCHED_STATS_EN
    , .sad_sum(sad_sum), .mb_done(mb_done)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ME core model ----------------
  bit            ack_fixed5 = 1'b0;
  bit            fixed_sad  = 1'b0;
  logic [SW-1:0] iss_sad[$];
  logic [MW-1:0] iss_mvec[$];

  initial begin : core_model
    int  wait_cnt;
    int  cur_delay;
    int  rel_wait;
    int  n;
    bit  prev_req;
    bit  req_low_seen;
    wait_cnt = 0; cur_delay = 1; rel_wait = 0; prev_req = 0; req_low_seen = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        me_ack = 1'b0; wait_cnt = 0; prev_req = 0; req_low_seen = 0;
      end else begin
        if (me_ack) begin
          if (req_low_seen) chk("req_rearm_before_ack_low", me_req, 1'b0);
          if (!me_req) begin
            req_low_seen = 1;
            if (rel_wait == 0) begin me_ack = 1'b0; req_low_seen = 0; end
            else rel_wait--;
          end
        end else begin
          if (prev_req) chk("req_held_until_ack", me_req, 1'b1);
          if (me_req) begin
            if (!prev_req) begin
              wait_cnt  = 0;
              cur_delay = ack_fixed5 ? 5 : $urandom_range(1, 6);
            end
            if (wait_cnt >= cur_delay) begin
              n = iss_sad.size();
              chk("mb_x_at_req", mb_x, n % C);
              chk("mb_y_at_req", mb_y, n / C);
              me_min_sad  = fixed_sad ? SW'(10 * (n + 1)) : SW'($urandom);
              me_min_mvec = MW'($urandom);
              iss_sad.push_back(me_min_sad);
              iss_mvec.push_back(me_min_mvec);
              me_ack   = 1'b1;
              rel_wait = $urandom_range(0, 2);
            end else begin
              wait_cnt++;
            end
          end
        end
        prev_req = me_req;
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  bit ready_hold   = 1'b0;
  bit ready_always = 1'b0;

  initial begin : ready_driver
    forever begin
      @(posedge clk); #1;
      res_ready = ready_hold ? 1'b0 : (ready_always ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
  end

  // ---------------- result / done checker ----------------
  int            acc_cnt = 0;
  int            done_cnt = 0;
  bit            last_aborted = 0;
  logic [SW:0]   acc_sum = '0;

  initial begin : result_checker
    bit            prev_hold;
    bit            prev_done;
    logic [SW-1:0] h_sad;
    logic [MW-1:0] h_mvec;
    logic [CW-1:0] h_x, h_y;
    int            k;
    prev_hold = 0; prev_done = 0; h_sad = '0; h_mvec = '0; h_x = '0; h_y = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 0; prev_done = 0;
      end else begin
        if (prev_hold) begin
          chk("valid_held_without_ready", res_valid, 1'b1);
          chk("stall_sad_stable", res_sad, h_sad);
          chk("stall_mvec_stable", res_mvec, h_mvec);
          chk("stall_x_stable", res_mb_x, h_x);
          chk("stall_y_stable", res_mb_y, h_y);
          chk("stall_req_low", me_req, 1'b0);
        end else if (res_valid) begin
          k = acc_cnt;
          if (k < iss_sad.size()) begin
            chk("res_mb_x", res_mb_x, k % C);
            chk("res_mb_y", res_mb_y, k / C);
            chk("res_sad", res_sad, iss_sad[k]);
            chk("res_mvec", res_mvec, iss_mvec[k]);
          end else begin
            chk("result_without_search", k, iss_sad.size());
          end
        end
        if (res_valid && res_ready) begin
          acc_cnt++;
          acc_sum = acc_sum + (SW+1)'(res_sad);
        end
        prev_hold = res_valid && !res_ready;
        h_sad = res_sad; h_mvec = res_mvec; h_x = res_mb_x; h_y = res_mb_y;
        if (done) begin
          chk("done_single_cycle", prev_done, 1'b0);
          done_cnt++;
          last_aborted = done_aborted;
        end
        prev_done = done;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  // mode 0: plain frame, 1: abort in REQ of MB 'at', 2: abort in PUSH of MB 'at',
  // 3: 10-cycle output stall on MB 'at'
  task automatic run_frame(input int mode, input int at, input bit extra_start);
    int guard;
    int exp_acc;
    int exp_iss;
    iss_sad.delete(); iss_mvec.delete();
    acc_cnt = 0; done_cnt = 0; acc_sum = '0;
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("req_one_cycle_after_start", me_req, 1'b1);
    if (extra_start && mode == 0) begin
      step(); start = 1'b1; step(); start = 1'b0;
    end
    if (mode == 1) begin
      guard = 0;
      while (!(me_req && !me_ack && iss_sad.size() == at) && guard < 400) begin step(); guard++; end
      chk("abort_point_reached", guard < 400, 1'b1);
      abort = 1'b1; step(); abort = 1'b0;
    end else if (mode == 2 || mode == 3) begin
      guard = 0;
      while (!(iss_sad.size() == at + 1 && !res_valid) && guard < 400) begin step(); guard++; end
      ready_hold = 1'b1;
      while (!res_valid && guard < 400) begin step(); guard++; end
      chk("stall_point_reached", guard < 400, 1'b1);
      if (mode == 2) begin
        abort = 1'b1; step(); abort = 1'b0;
      end else begin
        repeat (10) step();
      end
      ready_hold = 1'b0;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 600) begin step(); guard++; end
    chk("frame_done_timeout", done_cnt > 0, 1'b1);
    repeat (3) step();
    exp_acc = (mode == 1) ? at : (mode == 2) ? at + 1 : C * R;
    exp_iss = (mode == 1 || mode == 2) ? at + 1 : C * R;
    chk("done_count", done_cnt, 1);
    chk("done_aborted", last_aborted, (mode == 1 || mode == 2));
    chk("results_delivered", acc_cnt, exp_acc);
    chk("searches_issued", iss_sad.size(), exp_iss);
    chk("idle_after_frame", busy, 1'b0);
    chk("res_valid_idle", res_valid, 1'b0);
`ifdef ME_SCHED_STATS_EN
    chk("stats_mb_done", mb_done, acc_cnt);
    chk("stats_sad_sum", sad_sum, acc_sum);
`endif
    $display("frame mode=%0d at=%0d extra_start=%0d delivered=%0d aborted=%0d",
             mode, at, extra_start, acc_cnt, last_aborted);
  endtask

  initial begin : main
    int guard;
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_done_aborted", done_aborted, 1'b0);
    chk("rst_me_req", me_req, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_mb_xy", {mb_x, mb_y}, '0);
    chk("rst_res", {res_sad, res_mvec, res_mb_x, res_mb_y}, '0);
    step(); rst_n = 1'b1;

    // T1 + T6: 2x2 frame, ack after 5 cycles, ready held high, SADs 10..40
    ack_fixed5 = 1'b1; fixed_sad = 1'b1; ready_always = 1'b1;
    run_frame(0, 0, 1'b0);
`ifdef ME_SCHED_STATS_EN
    chk("t6_sad_sum_100", sad_sum, 100);
    chk("t6_mb_done_4", mb_done, 4);
`endif
    ack_fixed5 = 1'b0; fixed_sad = 1'b0; ready_always = 1'b0;

    // T2: stall output for 10 cycles on MB (1,0)
    run_frame(3, 1, 1'b0);
    // T3: abort while MB (1,0) is requested
    run_frame(1, 1, 1'b0);
    // T4: start while busy, then start&abort together in IDLE
    run_frame(0, 0, 1'b1);
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("start_abort_idle_busy", busy, 1'b0);
      chk("start_abort_idle_req", me_req, 1'b0);
      step();
    end
    $display("start&abort in idle: busy=%0d", busy);

    // T5: reset while REQ with ack high
    iss_sad.delete(); iss_mvec.delete();
    start = 1'b1; step(); start = 1'b0;
    guard = 0;
    while (!me_ack && guard < 50) begin step(); guard++; end
    chk("t5_ack_seen", me_ack, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_me_req", me_req, 1'b0);
    chk("t5_res_valid", res_valid, 1'b0);
    chk("t5_outputs", {done, done_aborted, mb_x, mb_y, res_sad, res_mvec, res_mb_x, res_mb_y}, '0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("t5_idle_after_release", busy, 1'b0);
    $display("reset during REQ: outputs cleared busy=%0d", busy);
    run_frame(0, 0, 1'b0);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int m;
      m = $urandom_range(0, 3);
      run_frame(m, $urandom_range(0, C * R - 1), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
